sprite_bitmap_writer: RTL and testbench
=======================================

Name: sprite_bitmap_writer

Overview:
- Writer side of the RGB332 sprite bitmap format used by the bitmap drawing blocks.
- Accepts a stream of 24-bit RGB pixels with a transparency flag, quantizes each pixel to 8-bit RGB332 and maps transparency to 8'hFF.
- Writes each pixel into a sprite RAM at auto-generated (X, Y) coordinates in raster order.
- Sits between the host/loader path and the sprite RAM that the bitmap readers later index with offsetX/offsetY.

Parameters:
- OBJECT_WIDTH_X, 100, sprite width in pixels (1..2047).
- OBJECT_HEIGHT_Y, 20, sprite height in pixels (1..2047).

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a new sprite load
- pixel_valid  in  1  pixel_rgb/pixel_transparent are valid
- pixel_ready  out  1  block accepts the pixel this cycle
- pixel_rgb  in  24  {R[7:0], G[7:0], B[7:0]}
- pixel_transparent  in  1  1 = pixel is transparent
- wr_en  out  1  write request to sprite RAM
- wr_ready  in  1  RAM accepts the write this cycle
- wr_addrX  out  11  column of the write, 0..OBJECT_WIDTH_X-1
- wr_addrY  out  11  row of the write, 0..OBJECT_HEIGHT_Y-1
- wr_data  out  8  RGB332 value
- busy  out  1  a load is in progress
- done  out  1  one-cycle pulse after the last write is accepted

Behaviour:
- Clock and reset: single clock clk; reset resetN is asynchronous, active-low.
- Reset values: all outputs 0; state IDLE; X/Y counters 0.
- FSM state IDLE: pixel_ready=0, busy=0. start -> LOAD with counters cleared.
- FSM state LOAD: busy=1.
- FSM state FLUSH: busy=1; the final write is held until wr_ready. Write accepted -> DONE.
- FSM state DONE: done=1 for exactly one cycle; busy=0; -> IDLE.
- Output register: a one-entry output register holds wr_en/addr/data.
- pixel_ready rule: pixel_ready = (state==LOAD) && (!wr_en || wr_ready). This gives full throughput of 1 pixel/cycle, with no combinational path from pixel_valid to pixel_ready.
- Pixel acceptance: on pixel_valid && pixel_ready, the register loads the next cycle.
  - wr_en=1
  - wr_addrX/wr_addrY = current counters
  - wr_data = encoded pixel
- Write completion: wr_en && wr_ready with no new pixel -> wr_en=0 next cycle.
- Latency: 1 cycle from pixel acceptance to wr_en.
- Encoding (truncation): {R[7:5], G[7:5], B[7:6]}.
- Transparency: pixel_transparent=1 -> wr_data=8'hFF regardless of RGB.
- Opaque-white collision: an opaque pixel that encodes to 8'hFF is written as 8'hFE, so it is never read back as transparent.
- Counters: X increments per accepted pixel.
  - X==OBJECT_WIDTH_X-1: X wraps to 0 and Y increments.
  - Accepting pixel (W-1, H-1): -> FLUSH; pixel_ready drops the next cycle.
- start while busy: ignored.
- pixel_valid in IDLE/FLUSH/DONE: ignored, not consumed.
- wr_ready held low: wr_en, addr and data hold stable; pixel_ready=0.
- Reset mid-load: immediate return to IDLE, wr_en=0, partial sprite left in RAM, no done pulse.

Optional Feature:
- Macro: SPRITE_WRITER_DITHER_EN.
- When defined: a 2x2 ordered dither is added before truncation.
  - Threshold from {Y[0], X[0]}: 00->0, 01->2, 10->3, 11->1.
  - Scaled per channel: R,G by 8 (threshold*8); B by 16.
  - Each channel saturates at 255 before truncation.
  - Transparency and 8'hFE substitution apply after dithering.
- When undefined: pure truncation; no extra logic.

Decomposition:
- Package sprite_bitmap_pkg:
  - TRANSPARENT_ENCODING=8'hFF
  - OPAQUE_WHITE_SUB=8'hFE
  - COORD_W=11
  - writer_state_t enum {IDLE, LOAD, FLUSH, DONE}
  - rgb332_t packed struct {r[2:0], g[2:0], b[1:0]}
- Sub-module rgb332_quantizer: purely combinational; inputs rgb, transparent, x0, y0 (x0/y0 used only under the dither macro); output rgb332_t.

Test Plan:
- 4x2 sprite, start, 8 pixels of 24'hFF0000 with wr_ready=1 -> 8 writes of 8'hE0 at (0,0)..(3,1), one per cycle; done one cycle after the last accepted write; busy=0 after.
- pixel 24'h123456 opaque -> wr_data 8'h05; same pixel with pixel_transparent=1 -> 8'hFF.
- pixel 24'hFFFFFF opaque -> 8'hFE; 24'hE0E0C0 opaque -> 8'hFF collision -> 8'hFE.
- wr_ready=0 for 5 cycles mid-row at X=2 -> pixel_ready=0, wr_addrX=2 and wr_data stable; resume with no lost or duplicated pixel.
- resetN low during row 1 of a 100x20 sprite -> wr_en=0 and busy=0 immediately; new start restarts at (0,0).
- With SPRITE_WRITER_DITHER_EN, pixel 24'h1C1C30 at (1,0) -> R/G 28+16=44 -> 3'b001, B 48+32=80 -> 2'b01 -> 8'h25; at (0,0) -> 8'h00.

Source files
------------

// File: rtl/sprite_bitmap_pkg.sv
// +----------------------------------------------------------------------+
// | sprite_bitmap_pkg : shared types and constants for the RGB332 sprite  |
// |                     bitmap writer                                     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

package sprite_bitmap_pkg;

    localparam logic [7:0] TRANSPARENT_ENCODING = 8'hFF;
    localparam logic [7:0] OPAQUE_WHITE_SUB     = 8'hFE;
    localparam int         COORD_W              = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } writer_state_t;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb332_t;

endpackage

`default_nettype wire

// File: rtl/rgb332_quantizer.sv
// +----------------------------------------------------------------------+
// | rgb332_quantizer : combinational RGB888 -> RGB332 encoder with        |
// |                    transparency and opaque-white remapping.           |
// | Optional 2x2 ordered dither under SPRITE_WRITER_DITHER_EN.            |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module rgb332_quantizer
    import sprite_bitmap_pkg::*;
(
    input  logic [23:0] rgb,
    input  logic        transparent,
    input  logic        x0,
    input  logic        y0,
    output rgb332_t     q
);

    logic [7:0] w_r;
    logic [7:0] w_g;
    logic [7:0] w_b;

`ifdef SPRITE_WRITER_DITHER_EN
    logic [1:0] w_thr;
    logic [8:0] w_r_sum;
    logic [8:0] w_g_sum;
    logic [8:0] w_b_sum;

    // Bayer 2x2 ordering indexed by {y0, x0}
    always_comb begin
        w_thr = 2'd0;
        case ({y0, x0})
            2'b00:   w_thr = 2'd0;
            2'b01:   w_thr = 2'd2;
            2'b10:   w_thr = 2'd3;
            default: w_thr = 2'd1;
        endcase
    end

    assign w_r_sum = {1'b0, rgb[23:16]} + {4'b0, w_thr, 3'b0};
    assign w_g_sum = {1'b0, rgb[15:8]}  + {4'b0, w_thr, 3'b0};
    assign w_b_sum = {1'b0, rgb[7:0]}   + {3'b0, w_thr, 4'b0};

    assign w_r = w_r_sum[8] ? 8'hFF : w_r_sum[7:0];
    assign w_g = w_g_sum[8] ? 8'hFF : w_g_sum[7:0];
    assign w_b = w_b_sum[8] ? 8'hFF : w_b_sum[7:0];
`else
    logic w_unused_coords;

    assign w_unused_coords = x0 ^ y0;
    assign w_r = rgb[23:16];
    assign w_g = rgb[15:8];
    assign w_b = rgb[7:0];
`endif

    rgb332_t w_trunc;
    logic    w_unused_lsbs;

    assign w_trunc       = '{r: w_r[7:5], g: w_g[7:5], b: w_b[7:6]};
    assign w_unused_lsbs = ^{w_r[4:0], w_g[4:0], w_b[5:0]};

    // An opaque pixel must never alias the transparent code
    always_comb begin
        q = w_trunc;
        if (transparent) begin
            q = rgb332_t'(TRANSPARENT_ENCODING);
        end else if (w_trunc == rgb332_t'(TRANSPARENT_ENCODING)) begin
            q = rgb332_t'(OPAQUE_WHITE_SUB);
        end
    end

endmodule

`default_nettype wire

// File: rtl/sprite_bitmap_writer.sv
// +----------------------------------------------------------------------+
// | sprite_bitmap_writer : streams RGB pixels into a sprite RAM as RGB332 |
// |                        in raster order. Dither: SPRITE_WRITER_DITHER_EN|
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module sprite_bitmap_writer
    import sprite_bitmap_pkg::*;
#(
    parameter int OBJECT_WIDTH_X  = 100,
    parameter int OBJECT_HEIGHT_Y = 20
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               start,
    input  logic               pixel_valid,
    output logic               pixel_ready,
    input  logic [23:0]        pixel_rgb,
    input  logic               pixel_transparent,
    output logic               wr_en,
    input  logic               wr_ready,
    output logic [COORD_W-1:0] wr_addrX,
    output logic [COORD_W-1:0] wr_addrY,
    output logic [7:0]         wr_data,
    output logic               busy,
    output logic               done
);

    localparam logic [COORD_W-1:0] c_last_x = COORD_W'(OBJECT_WIDTH_X - 1);
    localparam logic [COORD_W-1:0] c_last_y = COORD_W'(OBJECT_HEIGHT_Y - 1);

    writer_state_t      r_state;
    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    rgb332_t            w_pixel_q;
    logic               w_accept;
    logic               w_write_done;
    logic               w_last_pixel;

    rgb332_quantizer u_quant (
        .rgb         (pixel_rgb),
        .transparent (pixel_transparent),
        .x0          (r_x[0]),
        .y0          (r_y[0]),
        .q           (w_pixel_q)
    );

    // Depends only on registered state and wr_ready, never on pixel_valid
    assign pixel_ready  = (r_state == LOAD) && (!wr_en || wr_ready);
    assign w_accept     = pixel_valid && pixel_ready;
    assign w_write_done = wr_en && wr_ready;
    assign w_last_pixel = (r_x == c_last_x) && (r_y == c_last_y);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state  <= IDLE;
            r_x      <= '0;
            r_y      <= '0;
            wr_en    <= 1'b0;
            wr_addrX <= '0;
            wr_addrY <= '0;
            wr_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= LOAD;
                        busy    <= 1'b1;
                        r_x     <= '0;
                        r_y     <= '0;
                    end
                end
                LOAD: begin
                    if (w_accept) begin
                        wr_en    <= 1'b1;
                        wr_addrX <= r_x;
                        wr_addrY <= r_y;
                        wr_data  <= w_pixel_q;
                        if (w_last_pixel) begin
                            r_state <= FLUSH;
                        end else if (r_x == c_last_x) begin
                            r_x <= '0;
                            r_y <= r_y + 1'b1;
                        end else begin
                            r_x <= r_x + 1'b1;
                        end
                    end else if (w_write_done) begin
                        wr_en <= 1'b0;
                    end
                end
                FLUSH: begin
                    if (w_write_done) begin
                        wr_en   <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sprite_bitmap_writer.sv
// +----------------------------------------------------------------------+
// | tb_sprite_bitmap_writer : randomized bench with a behavioural model   |
// |                           for sprite_bitmap_writer (4x2 sprite).      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_sprite_bitmap_writer;

    localparam int W = 4;
    localparam int H = 2;
    localparam int N = W * H;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        start = 1'b0;
    logic        pixel_valid = 1'b0;
    logic        pixel_ready;
    logic [23:0] pixel_rgb = 24'h0;
    logic        pixel_transparent = 1'b0;
    logic        wr_en;
    logic        wr_ready = 1'b0;
    logic [10:0] wr_addrX;
    logic [10:0] wr_addrY;
    logic [7:0]  wr_data;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    sprite_bitmap_writer #(
        .OBJECT_WIDTH_X  (W),
        .OBJECT_HEIGHT_Y (H)
    ) dut (
        .clk               (clk),
        .resetN            (resetN),
        .start             (start),
        .pixel_valid       (pixel_valid),
        .pixel_ready       (pixel_ready),
        .pixel_rgb         (pixel_rgb),
        .pixel_transparent (pixel_transparent),
        .wr_en             (wr_en),
        .wr_ready          (wr_ready),
        .wr_addrX          (wr_addrX),
        .wr_addrY          (wr_addrY),
        .wr_data           (wr_data),
        .busy              (busy),
        .done              (done)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

`ifdef SPRITE_WRITER_DITHER_EN
    int thr_tab [4] = '{0, 2, 3, 1};
`endif

    // Reference encoding straight from the format rules
    function automatic int enc(input logic [23:0] rgb, input bit tr, input int x, input int y);
        int r, g, b, v;
        r = int'(rgb[23:16]);
        g = int'(rgb[15:8]);
        b = int'(rgb[7:0]);
`ifdef SPRITE_WRITER_DITHER_EN
        r = r + thr_tab[(y % 2) * 2 + (x % 2)] * 8;
        g = g + thr_tab[(y % 2) * 2 + (x % 2)] * 8;
        b = b + thr_tab[(y % 2) * 2 + (x % 2)] * 16;
        if (r > 255) r = 255;
        if (g > 255) g = 255;
        if (b > 255) b = 255;
`endif
        v = (r / 32) * 32 + (g / 32) * 4 + (b / 64);
        if (tr) return 255;
        if (v == 255) return 254;
        return v;
    endfunction

    typedef struct { int x; int y; int data; } wr_t;

    // Model: outstanding write register as a queue, plus load progress
    wr_t mq[$];
    bit  m_active = 1'b0;
    bit  m_done   = 1'b0;
    int  m_acc    = 0;

    always @(negedge clk) begin
        bit exp_en, exp_rdy, hs, acc, was_done;
        int acc_pre;
        if (!resetN) begin
            mq.delete();
            m_active = 1'b0;
            m_done   = 1'b0;
            m_acc    = 0;
        end
        exp_en  = (mq.size() != 0);
        exp_rdy = m_active && (m_acc < N) && (!exp_en || wr_ready);
        check("wr_en", wr_en, exp_en);
        check("busy", busy, m_active);
        check("done", done, m_done);
        check("pixel_ready", pixel_ready, exp_rdy);
        if (exp_en) begin
            check("wr_addrX", wr_addrX, mq[0].x);
            check("wr_addrY", wr_addrY, mq[0].y);
            check("wr_data", wr_data, mq[0].data);
        end
        if (resetN) begin
            hs       = exp_en && wr_ready;
            acc      = exp_rdy && pixel_valid;
            was_done = m_done;
            acc_pre  = m_acc;
            m_done   = 1'b0;
            if (hs) void'(mq.pop_front());
            if (acc) begin
                mq.push_back('{m_acc % W, m_acc / W,
                               enc(pixel_rgb, pixel_transparent, m_acc % W, m_acc / W)});
                m_acc++;
            end
            if (hs && acc_pre == N) begin
                m_done   = 1'b1;
                m_active = 1'b0;
            end
            if (start && !m_active && !was_done) begin
                m_active = 1'b1;
                m_acc    = 0;
            end
        end
    end

    // Log of writes the DUT actually completed, for directed literal checks
    wr_t dlog[$];
    int  hs_cyc[$];
    int  cyc = 0;
    int  done_cyc = -1;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (resetN) begin
            if (wr_en && wr_ready) begin
                dlog.push_back('{int'(wr_addrX), int'(wr_addrY), int'(wr_data)});
                hs_cyc.push_back(cyc);
            end
            if (done) done_cyc = cyc;
        end
    end

    logic [23:0] drv_rgb [N];
    bit          drv_tr  [N];
    logic [23:0] tbl_rgb [8];
    bit          tbl_tr  [8];

    task automatic set_pixel(input int mode, input int k);
        logic [23:0] rgb;
        bit          tr;
        if (mode == 0) begin
            rgb = 24'hFF0000;
            tr  = 1'b0;
        end else if (mode == 1) begin
            rgb = tbl_rgb[k % 8];
            tr  = tbl_tr[k % 8];
        end else begin
            rgb = 24'($urandom);
            tr  = ($urandom_range(3) == 0);
            if ($urandom_range(5) == 0) rgb = 24'hE0E0C0 | 24'($urandom_range(63));
        end
        pixel_rgb         = rgb;
        pixel_transparent = tr;
        if (k < N) begin
            drv_rgb[k] = rgb;
            drv_tr[k]  = tr;
        end
    endtask

    task automatic run_sprite(input int mode, input int vprob, input int rprob,
                              input bit stall_en, input int abort_at, input bit rand_start);
        int k = 0;
        int cyc_cnt = 0;
        int stall_left = 0;
        bit acc;
        bit seen_done = 1'b0;
        bit aborted = 1'b0;
        dlog.delete();
        hs_cyc.delete();
        done_cyc = -1;
        @(posedge clk); #1;
        start = 1'b1;
        set_pixel(mode, 0);
        pixel_valid = ($urandom_range(99) < vprob);
        wr_ready    = ($urandom_range(99) < rprob);
        @(posedge clk); #1;
        start = 1'b0;
        while (!seen_done && cyc_cnt < 300) begin
            @(negedge clk);
            acc       = pixel_valid && pixel_ready;
            seen_done = done;
            if (stall_left > 0 && !wr_ready) begin
                check("stall_wr_en", wr_en, 1);
                check("stall_addrX", wr_addrX, 2);
                check("stall_data", wr_data, enc(drv_rgb[2], drv_tr[2], 2, 0));
                check("stall_ready", pixel_ready, 0);
            end
            if (stall_en && acc && k == 2) stall_left = 6;
            @(posedge clk); #1;
            if (acc) begin
                k++;
                set_pixel(mode, k);
                if (abort_at > 0 && k == abort_at) begin
                    #2 resetN = 1'b0;
                    #1;
                    check("rst_wr_en", wr_en, 0);
                    check("rst_busy", busy, 0);
                    check("rst_pixel_ready", pixel_ready, 0);
                    @(posedge clk); #1;
                    resetN = 1'b1;
                    aborted = 1'b1;
                    break;
                end
            end
            pixel_valid = ($urandom_range(99) < vprob);
            start = rand_start && (k < N - 1) && ($urandom_range(15) == 0);
            if (stall_left > 0) stall_left--;
            wr_ready = (stall_left > 0) ? 1'b0 : ($urandom_range(99) < rprob);
            cyc_cnt++;
        end
        if (!seen_done && !aborted) begin
            n_checks++;
            $display("FAIL sprite_timeout: no done after %0d cycles (mode %0d)", cyc_cnt, mode);
        end
        @(posedge clk); #1;
        start       = 1'b0;
        pixel_valid = 1'b0;
        wr_ready    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef SPRITE_WRITER_DITHER_EN
        tbl_rgb = '{24'h1C1C30, 24'h1C1C30, 24'hFFFFFF, 24'hE0E0C0,
                    24'h000000, 24'h1F1F3F, 24'h20E040, 24'hFF00FF};
        tbl_tr  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`else
        tbl_rgb = '{24'h123456, 24'h123456, 24'hFFFFFF, 24'hE0E0C0,
                    24'h000000, 24'h1F1F3F, 24'h20E040, 24'hFF00FF};
        tbl_tr  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`endif
        @(negedge clk);
        check("reset_wr_en", wr_en, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_wr_data", wr_data, 0);
        @(posedge clk); #1;
        resetN = 1'b1;

        // Solid red, full throughput
        run_sprite(0, 100, 100, 1'b0, 0, 1'b0);
        check("red_count", dlog.size(), 8);
        if (dlog.size() == 8) begin
            for (int i = 0; i < 8; i++) check("red_data", dlog[i].data, 8'hE0);
            check("red_x3", dlog[3].x, 3);
            check("red_y4", dlog[4].y, 1);
            check("red_last_x", dlog[7].x, 3);
            check("red_last_y", dlog[7].y, 1);
            check("red_back_to_back", hs_cyc[7] - hs_cyc[0], 7);
            check("red_done_timing", done_cyc, hs_cyc[7] + 1);
        end
        @(negedge clk);
        check("red_busy_after", busy, 0);

        // Encoding corner cases
        run_sprite(1, 100, 100, 1'b0, 0, 1'b0);
        check("enc_count", dlog.size(), 8);
        if (dlog.size() == 8) begin
`ifdef SPRITE_WRITER_DITHER_EN
            check("dither_00", dlog[0].data, 8'h00);
            check("dither_10", dlog[1].data, 8'h25);
`else
            check("enc_123456", dlog[0].data, 8'h05);
            check("enc_123456_tr", dlog[1].data, 8'hFF);
            check("enc_white", dlog[2].data, 8'hFE);
            check("enc_collision", dlog[3].data, 8'hFE);
            check("enc_20E040", dlog[6].data, 8'h3D);
`endif
            check("enc_tr_last", dlog[7].data, 8'hFF);
        end

        // Back-pressure at X=2 for five cycles
        run_sprite(2, 100, 100, 1'b1, 0, 1'b0);
        check("stall_count", dlog.size(), 8);
        if (dlog.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                check("stall_order_x", dlog[i].x, i % W);
                check("stall_order_y", dlog[i].y, i / W);
            end
        end

        // Reset during row 1, then a clean restart
        run_sprite(2, 80, 80, 1'b0, 5, 1'b0);
        run_sprite(2, 80, 80, 1'b0, 0, 1'b0);
        check("restart_count", dlog.size(), 8);
        if (dlog.size() != 0) begin
            check("restart_x0", dlog[0].x, 0);
            check("restart_y0", dlog[0].y, 0);
        end

        for (int s = 0; s < 25; s++) begin
            run_sprite(2, $urandom_range(100, 30), $urandom_range(100, 30), 1'b0, 0, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
